// File: rtl/nrf24_rx_reader_pkg.sv
// Shared nRF24L01 definitions: command opcodes, register map, STATUS bits,
// controller state encoding and the power-up configuration frame ROM.
package nrf24_rx_reader_pkg;

  localparam logic [7:0] CMD_W_REGISTER   = 8'h20;
  localparam logic [7:0] CMD_R_RX_PAYLOAD = 8'h61;
  localparam logic [7:0] CMD_FLUSH_RX     = 8'hE2;
  localparam logic [7:0] CMD_NOP          = 8'hFF;

  localparam logic [4:0] REG_CONFIG   = 5'h00;
  localparam logic [4:0] REG_EN_AA    = 5'h01;
  localparam logic [4:0] REG_STATUS   = 5'h07;
  localparam logic [4:0] REG_RX_PW_P0 = 5'h11;

  localparam int unsigned STATUS_RX_DR  = 6;
  localparam int unsigned STATUS_TX_DS  = 5;
  localparam int unsigned STATUS_MAX_RT = 4;

  localparam logic [7:0] CONFIG_VAL = 8'h0B;  // PWR_UP | PRIM_RX | EN_CRC, 1-byte CRC
  localparam logic [7:0] EN_AA_VAL  = 8'h00;
  localparam logic [7:0] RX_PW_VAL  = 8'h01;
  localparam logic [7:0] STATUS_CLR = 8'((32'd1 << STATUS_RX_DR) | (32'd1 << STATUS_TX_DS) |
                                         (32'd1 << STATUS_MAX_RT));

  localparam logic [3:0] CFG_LAST_IDX = 4'd8;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_CFG,
    ST_SETTLE,
    ST_LISTEN,
    ST_RD_STATUS,
    ST_RD_PLD,
    ST_CLR_IRQ
  } state_t;

  typedef struct packed {
    logic [7:0] tx;
    logic       hold;
  } spi_byte_t;

  function automatic logic [7:0] w_reg(input logic [4:0] addr);
    return CMD_W_REGISTER | {3'b000, addr};
  endfunction

  // hold=0 marks the last byte of each CSN frame
  function automatic spi_byte_t cfg_rom(input logic [3:0] idx);
    spi_byte_t b;
    case (idx)
      4'd0:    b = '{tx: w_reg(REG_CONFIG),   hold: 1'b1};
      4'd1:    b = '{tx: CONFIG_VAL,          hold: 1'b0};
      4'd2:    b = '{tx: w_reg(REG_EN_AA),    hold: 1'b1};
      4'd3:    b = '{tx: EN_AA_VAL,           hold: 1'b0};
      4'd4:    b = '{tx: w_reg(REG_RX_PW_P0), hold: 1'b1};
      4'd5:    b = '{tx: RX_PW_VAL,           hold: 1'b0};
      4'd6:    b = '{tx: w_reg(REG_STATUS),   hold: 1'b1};
      4'd7:    b = '{tx: STATUS_CLR,          hold: 1'b0};
      4'd8:    b = '{tx: CMD_FLUSH_RX,        hold: 1'b0};
      default: b = '{tx: CMD_NOP,             hold: 1'b0};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nrf24_rx_reader.sv
// nRF24L01 receive reader: powers up and configures the radio through a byte-level
// SPI master, then on every IRQ reads STATUS, fetches a 1-byte payload and clears flags.
module nrf24_rx_reader
  import nrf24_rx_reader_pkg::*;
#(
  parameter int PWRUP_CYC  = 500000,
  parameter int SETTLE_CYC = 15000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  input  logic [7:0] spi_rx,
  input  logic       spi_done,
  output logic       spi_hold_csn,
  output logic       nrf_ce,
  input  logic       nrf_irq_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       cfg_done
);

  localparam logic [31:0] PWRUP_LAST  = 32'(PWRUP_CYC - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);

  state_t      state_r, state_nxt_s, after_s;
  logic [31:0] cnt_r, cnt_nxt_s;
  logic [3:0]  idx_r, idx_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        irq_meta_r, irq_sync_r;
  logic        spi_start_r, spi_start_nxt_s;
  logic [7:0]  spi_tx_r, spi_tx_nxt_s;
  logic        spi_hold_r, spi_hold_nxt_s;
  logic        ce_r, ce_nxt_s;
  logic        cfg_done_r, cfg_done_nxt_s;
  logic [7:0]  rx_data_r, rx_data_nxt_s;
  logic        rx_valid_r, rx_valid_nxt_s;
  spi_byte_t   cur_byte_s;
  logic        last_byte_s;

  // IRQ synchronizer; idles high so a reset never looks like a pending interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta_r <= 1'b1;
      irq_sync_r <= 1'b1;
    end else begin
      irq_meta_r <= nrf_irq_n;
      irq_sync_r <= irq_meta_r;
    end
  end

  // Byte to send in the current state/index and the state that follows its last byte
  always_comb begin
    cur_byte_s  = '{tx: CMD_NOP, hold: 1'b0};
    last_byte_s = 1'b1;
    after_s     = ST_LISTEN;
    case (state_r)
      ST_CFG: begin
        cur_byte_s  = cfg_rom(idx_r);
        last_byte_s = (idx_r == CFG_LAST_IDX);
        after_s     = ST_SETTLE;
      end
      ST_RD_STATUS: begin
        cur_byte_s  = '{tx: CMD_NOP, hold: 1'b0};
        last_byte_s = 1'b1;
        after_s     = spi_rx[STATUS_RX_DR] ? ST_RD_PLD : ST_CLR_IRQ;
      end
      ST_RD_PLD: begin
        if (idx_r == 4'd0) begin
          cur_byte_s  = '{tx: CMD_R_RX_PAYLOAD, hold: 1'b1};
          last_byte_s = 1'b0;
        end else begin
          cur_byte_s  = '{tx: CMD_NOP, hold: 1'b0};
          last_byte_s = 1'b1;
        end
        after_s = ST_CLR_IRQ;
      end
      ST_CLR_IRQ: begin
        if (idx_r == 4'd0) begin
          cur_byte_s  = '{tx: w_reg(REG_STATUS), hold: 1'b1};
          last_byte_s = 1'b0;
        end else begin
          cur_byte_s  = '{tx: STATUS_CLR, hold: 1'b0};
          last_byte_s = 1'b1;
        end
        after_s = ST_LISTEN;
      end
      default: begin
        cur_byte_s  = '{tx: CMD_NOP, hold: 1'b0};
        last_byte_s = 1'b1;
        after_s     = ST_LISTEN;
      end
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    idx_nxt_s       = idx_r;
    busy_nxt_s      = busy_r;
    spi_start_nxt_s = 1'b0;
    spi_tx_nxt_s    = spi_tx_r;
    spi_hold_nxt_s  = spi_hold_r;
    ce_nxt_s        = ce_r;
    cfg_done_nxt_s  = cfg_done_r;
    rx_data_nxt_s   = rx_data_r;
    rx_valid_nxt_s  = 1'b0;
    case (state_r)
      ST_PWRUP: begin
        if (cnt_r == PWRUP_LAST) begin
          cnt_nxt_s   = 32'd0;
          state_nxt_s = ST_CFG;
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          cnt_nxt_s      = 32'd0;
          ce_nxt_s       = 1'b1;
          cfg_done_nxt_s = 1'b1;
          state_nxt_s    = ST_LISTEN;
        end else begin
          cnt_nxt_s = cnt_r + 32'd1;
        end
      end
      ST_LISTEN: begin
        if (!irq_sync_r) begin
          state_nxt_s = ST_RD_STATUS;
        end else begin
          state_nxt_s = ST_LISTEN;
        end
      end
      ST_CFG, ST_RD_STATUS, ST_RD_PLD, ST_CLR_IRQ: begin
        // spi_done is only honoured while a byte is outstanding
        if (!busy_r) begin
          spi_start_nxt_s = 1'b1;
          busy_nxt_s      = 1'b1;
          spi_tx_nxt_s    = cur_byte_s.tx;
          spi_hold_nxt_s  = cur_byte_s.hold;
        end else if (spi_done) begin
          busy_nxt_s = 1'b0;
          if (last_byte_s) begin
            idx_nxt_s   = 4'd0;
            state_nxt_s = after_s;
            if (state_r == ST_RD_PLD) begin
              rx_data_nxt_s  = spi_rx;
              rx_valid_nxt_s = 1'b1;
            end else begin
              rx_valid_nxt_s = 1'b0;
            end
          end else begin
            idx_nxt_s = idx_r + 4'd1;
          end
        end else begin
          busy_nxt_s = busy_r;
        end
      end
      default: begin
        state_nxt_s = ST_PWRUP;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_PWRUP;
      cnt_r       <= 32'd0;
      idx_r       <= 4'd0;
      busy_r      <= 1'b0;
      spi_start_r <= 1'b0;
      spi_tx_r    <= 8'h00;
      spi_hold_r  <= 1'b0;
      ce_r        <= 1'b0;
      cfg_done_r  <= 1'b0;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      busy_r      <= busy_nxt_s;
      spi_start_r <= spi_start_nxt_s;
      spi_tx_r    <= spi_tx_nxt_s;
      spi_hold_r  <= spi_hold_nxt_s;
      ce_r        <= ce_nxt_s;
      cfg_done_r  <= cfg_done_nxt_s;
      rx_data_r   <= rx_data_nxt_s;
      rx_valid_r  <= rx_valid_nxt_s;
    end
  end

  assign spi_start    = spi_start_r;
  assign spi_tx       = spi_tx_r;
  assign spi_hold_csn = spi_hold_r;
  assign nrf_ce       = ce_r;
  assign cfg_done     = cfg_done_r;
  assign rx_data      = rx_data_r;
  assign rx_valid     = rx_valid_r;

endmodule
